// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - job, operand-feed and drain signals of the systolic array sequencer
interface systolic_ctrl_if #(
  parameter int N  = 4,
  parameter int KW = 8
);
  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   abort;
  logic                   busy;
  logic                   err;
  logic                   clr_accum;
  logic [N-1:0]           feed_en;
  logic [N*KW-1:0]        feed_idx;
  logic                   drain_valid;
  logic [$clog2(N)-1:0]   drain_row;
  logic                   drain_ready;
  logic                   done;

  modport master (
    output start, k_len, abort, drain_ready,
    input  busy, err, clr_accum, feed_en, feed_idx, drain_valid, drain_row, done
  );

  modport slave (
    input  start, k_len, abort, drain_ready,
    output busy, err, clr_accum, feed_en, feed_idx, drain_valid, drain_row, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for an N x N output-stationary systolic array
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          reset,
  systolic_ctrl_if.slave bus
);
  localparam int DW = $clog2(N);
  localparam int CW = KW + $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   k_ext;
  logic [CW-1:0]   t_next;
  logic [N-1:0]    lane_en;
  logic [N*KW-1:0] lane_idx;

  assign k_ext = CW'(k_reg);

  // Skew pattern for the feed step about to be presented: lane i is live for t in [i, i+K-1].
  always_comb begin
    t_next   = (state == S_CLEAR) ? '0 : cnt + 1'b1;
    lane_en  = '0;
    lane_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (t_next >= CW'(i) && t_next < CW'(i) + k_ext) begin
        lane_en[i]             = 1'b1;
        lane_idx[i*KW +: KW]   = KW'(t_next - CW'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      k_reg           <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.err         <= 1'b0;
      bus.clr_accum   <= 1'b0;
      bus.feed_en     <= '0;
      bus.feed_idx    <= '0;
      bus.drain_valid <= 1'b0;
      bus.drain_row   <= '0;
      bus.done        <= 1'b0;
    end else begin
      bus.err       <= 1'b0;
      bus.done      <= 1'b0;
      bus.clr_accum <= 1'b0;
      bus.feed_en   <= '0;
      bus.feed_idx  <= '0;
      if (state != S_IDLE && bus.abort) begin
        state           <= S_IDLE;
        cnt             <= '0;
        bus.busy        <= 1'b0;
        bus.drain_valid <= 1'b0;
        bus.drain_row   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.k_len != '0) begin
                k_reg         <= bus.k_len;
                state         <= S_CLEAR;
                bus.busy      <= 1'b1;
                bus.clr_accum <= 1'b1;
              end else begin
                bus.err <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            state        <= S_FEED;
            cnt          <= '0;
            bus.feed_en  <= lane_en;
            bus.feed_idx <= lane_idx;
          end
          S_FEED: begin
            if (cnt == k_ext + CW'(N - 2)) begin
              state <= S_FLUSH;
              cnt   <= '0;
            end else begin
              cnt          <= t_next;
              bus.feed_en  <= lane_en;
              bus.feed_idx <= lane_idx;
            end
          end
          S_FLUSH: begin
            if (cnt == CW'(N - 1)) begin
              state           <= S_DRAIN;
              cnt             <= '0;
              bus.drain_valid <= 1'b1;
              bus.drain_row   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            if (bus.drain_ready) begin
              if (bus.drain_row == DW'(N - 1)) begin
                state           <= S_DONE;
                bus.drain_valid <= 1'b0;
                bus.drain_row   <= '0;
                bus.done        <= 1'b1;
              end else begin
                bus.drain_row <= bus.drain_row + 1'b1;
              end
            end
          end
          S_DONE: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - randomized bench for systolic_ctrl against a cycle-count reference model
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .KW(KW)) bus ();
  systolic_ctrl #(.N(N), .KW(KW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a job is "cycle m_cyc since acceptance" plus rows accepted so far.
  bit m_busy, m_err;
  int m_k, m_cyc, m_rows;

  logic [N-1:0]  fe_hist [0:31];
  logic [KW-1:0] l3_hist [0:31];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit m_in_drain();
    return m_busy && m_rows < N && m_cyc >= m_k + 2*N + 1;
  endfunction

  task automatic compare_all();
    logic [N-1:0]    fe;
    logic [N*KW-1:0] fi;
    int t;
    fe = '0;
    fi = '0;
    t  = m_cyc - 2;
    if (m_busy && m_cyc >= 2 && m_cyc <= m_k + N)
      for (int i = 0; i < N; i++)
        if (t >= i && t <= i + m_k - 1) begin
          fe[i] = 1'b1;
          fi[i*KW +: KW] = KW'(t - i);
        end
    check("busy", bus.busy, m_busy);
    check("err", bus.err, m_err);
    check("clr_accum", bus.clr_accum, m_busy && m_cyc == 1);
    check("feed_en", bus.feed_en, fe);
    check("feed_idx", bus.feed_idx, fi);
    check("drain_valid", bus.drain_valid, m_in_drain());
    check("drain_row", bus.drain_row, m_in_drain() ? m_rows : 0);
    check("done", bus.done, m_busy && m_rows == N);
  endtask

  task automatic model_step();
    bit drain_now;
    drain_now = m_in_drain();
    m_err = 1'b0;
    if (!m_busy) begin
      if (bus.start) begin
        if (bus.k_len == '0) m_err = 1'b1;
        else begin
          m_busy = 1'b1;
          m_k    = int'(bus.k_len);
          m_cyc  = 1;
          m_rows = 0;
        end
      end
    end else if (bus.abort) begin
      m_busy = 1'b0;
    end else if (m_rows == N) begin
      m_busy = 1'b0;
    end else begin
      if (drain_now && bus.drain_ready) m_rows++;
      m_cyc++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_job(input int k, input int stall_row, input int stall_n,
                         input int abort_at, input bit rnd, input int exp_lat);
    int dones, lat, cyc, left;
    left  = stall_n;
    dones = 0;
    lat   = -1;
    bus.start = 1'b1; bus.k_len = KW'(k); bus.abort = 1'b0; bus.drain_ready = 1'b1;
    tick();
    cyc = 1;
    bus.start = 1'b0;
    for (int j = 0; j < 4000 && m_busy; j++) begin
      bus.abort = (cyc == abort_at);
      bus.start = (cyc == 4) || (rnd && $urandom_range(7) == 0);
      bus.k_len = KW'($urandom_range(255));
      if (rnd) bus.drain_ready = ($urandom_range(2) != 0);
      else if (m_in_drain() && m_rows == stall_row && left > 0) begin
        bus.drain_ready = 1'b0;
        left--;
      end else bus.drain_ready = 1'b1;
      tick();
      cyc++;
      if (cyc < 32) begin
        fe_hist[cyc] = bus.feed_en;
        l3_hist[cyc] = bus.feed_idx[3*KW +: KW];
      end
      if (bus.done) begin
        dones++;
        lat = cyc;
      end
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.drain_ready = 1'b1;
    check("job_idle_at_end", bus.busy, 0);
    if (abort_at > 0) check("abort_no_done", dones, 0);
    else check("done_count", dones, 1);
    if (exp_lat > 0) check("done_latency", lat, exp_lat);
  endtask

  task automatic reset_mid_drain(input int k);
    int beats;
    bus.start = 1'b1; bus.k_len = KW'(k); bus.drain_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 200 && !(m_in_drain() && m_rows == 1); j++) tick();
    check("reached_drain", bus.drain_valid, 1);
    #2 reset = 1'b1;
    m_busy = 1'b0;
    m_err  = 1'b0;
    #1 compare_all();
    @(negedge clk) reset = 1'b0;
    beats = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (bus.drain_valid) beats++;
    end
    check("no_beats_after_reset", beats, 0);
  endtask

  initial begin
    logic [N-1:0] fe_k3 [0:5];
    fe_k3[0] = 4'b0001; fe_k3[1] = 4'b0011; fe_k3[2] = 4'b0111;
    fe_k3[3] = 4'b1110; fe_k3[4] = 4'b1100; fe_k3[5] = 4'b1000;
    bus.start = 1'b0; bus.k_len = '0; bus.abort = 1'b0; bus.drain_ready = 1'b1;
    m_busy = 1'b0; m_err = 1'b0; m_k = 0; m_cyc = 0; m_rows = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    run_job(3, -1, 0, -1, 1'b0, 16);
    for (int j = 0; j < 6; j++) check("k3_feed_en", fe_hist[2+j], fe_k3[j]);
    for (int j = 0; j < 3; j++) check("k3_lane3_idx", l3_hist[5+j], j);

    run_job(1, -1, 0, -1, 1'b0, 14);
    for (int j = 0; j < N; j++) check("k1_onehot", fe_hist[2+j], 1 << j);

    run_job(3, 2, 5, -1, 1'b0, 21);

    bus.start = 1'b1; bus.k_len = '0;
    tick();
    bus.start = 1'b0;
    check("err_pulse", bus.err, 1);
    check("err_busy", bus.busy, 0);
    tick();
    check("err_clears", bus.err, 0);

    run_job(4, -1, 0, 4, 1'b0, 0);
    run_job(2, -1, 0, -1, 1'b0, 15);

    reset_mid_drain(5);
    run_job(255, -1, 0, -1, 1'b0, 268);

    for (int r = 0; r < 25; r++) begin
      int k, ab;
      k  = $urandom_range(12, 1);
      ab = ($urandom_range(3) == 0) ? $urandom_range(k + 3*N, 1) : -1;
      run_job(k, -1, 0, ab, 1'b1, 0);
      if ($urandom_range(4) == 0) begin
        bus.start = 1'b1; bus.k_len = '0;
        tick();
        bus.start = 1'b0;
      end
      repeat ($urandom_range(2)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
